nodf_module_intf: RTL and testbench

NODF_MODULE_INTF -- requirements
Module: nodf_module_intf

---
 rtl/nodf_mon_pkg.sv | 34 +++
 rtl/nodf_sat_counter.sv | 43 ++++
 rtl/nodf_module_intf.sv | 182 ++++++++++++++++++
 tb/tb_nodf_module_intf.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/nodf_mon_pkg.sv
// -----------------------------------------------------------------------------
// nodf_mon_pkg
// Shared definitions for the handshake monitor slice:
//   - monState_e : monitor FSM encoding (IDLE, BUSY, DONE_HOLD); value 3 unused
//   - MAX_CNT_W  : widest counter the helper function supports
//   - satInc     : saturating increment on the low 'width' bits of a value
// Build option: none in this file (NODF_LAT_STATS_EN is handled in the top).
// -----------------------------------------------------------------------------
package nodf_mon_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY      = 2'd1,
      DONE_HOLD = 2'd2
   } monState_e;

   localparam int MAX_CNT_W = 64;

   // Increments the low 'width' bits of 'value' and holds them at all-ones
   // instead of wrapping. Callers zero-extend into 64 bits and truncate the
   // result back, so one function serves every counter width up to 64.
   function automatic logic [MAX_CNT_W-1:0] satInc(input logic [MAX_CNT_W-1:0] value,
                                                   input int unsigned width);
      logic [MAX_CNT_W-1:0] mask;
      logic [MAX_CNT_W-1:0] field;
      mask  = ~({MAX_CNT_W{1'b1}} << width);
      field = value & mask;
      if (field == mask) begin
         return field;
      end
      return (field + 1'b1) & mask;
   endfunction

endpackage

// File: rtl/nodf_sat_counter.sv
// -----------------------------------------------------------------------------
// nodf_sat_counter
// CNT_W-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous reset, active low (clears the count)
//   en_i   - count one event this cycle
//   cnt_o  - current count (registered)
// Build option: none.
// -----------------------------------------------------------------------------
module nodf_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);
   import nodf_mon_pkg::*;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: bump by one on enable, saturating at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = CNT_W'(satInc(MAX_CNT_W'(cnt_q), CNT_W));
      end
   end

   // Count register; reset wins over any enable in the same cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/nodf_module_intf.sv
// -----------------------------------------------------------------------------
// nodf_module_intf
// Passive monitor for an ap_start/ap_ready/ap_done/ap_continue handshake.
// Tracks the transaction state, counts starts, completions and ready cycles,
// measures start-to-done latency and flags done pulses that arrive with no
// transaction in flight. Once 'finish' is seen everything freezes until reset.
// Ports:
//   clock, reset      - clock and synchronous active-low reset
//   ap_start/ap_ready/ap_done/ap_continue - observed handshake
//   finish            - end-of-simulation request
//   state             - 0=IDLE, 1=BUSY, 2=DONE_HOLD
//   start_cnt, done_cnt, ready_cnt - saturating event counters
//   last_lat          - latency of the most recent completed transaction
//   err_done_idle     - sticky: done seen while idle or holding
//   finished          - sticky: finish has been sampled
//   min_lat, max_lat  - latency extremes (only with NODF_LAT_STATS_EN)
// Build option: define NODF_LAT_STATS_EN to add min_lat/max_lat.
// -----------------------------------------------------------------------------
module nodf_module_intf #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   input  logic             ap_continue,
   input  logic             finish,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] start_cnt,
   output logic [CNT_W-1:0] done_cnt,
   output logic [CNT_W-1:0] ready_cnt,
   output logic [CNT_W-1:0] last_lat,
   output logic             err_done_idle,
   output logic             finished
`ifdef NODF_LAT_STATS_EN
   ,
   output logic [CNT_W-1:0] min_lat,
   output logic [CNT_W-1:0] max_lat
`endif
);
   import nodf_mon_pkg::*;

   monState_e        state_q;
   monState_e        state_d;
   logic [CNT_W-1:0] lat_q;
   logic [CNT_W-1:0] lat_d;
   logic [CNT_W-1:0] lastLat_q;
   logic [CNT_W-1:0] lastLat_d;
   logic             err_q;
   logic             finished_q;

   logic             startEv;
   logic             doneEv;
   logic             errEv;
   logic             live;

`ifdef NODF_LAT_STATS_EN
   logic [CNT_W-1:0] minLat_q;
   logic [CNT_W-1:0] maxLat_q;
`endif

   // After finish has been registered the monitor stops evolving; only the
   // sticky flags keep listening.
   assign live = ~finished_q;

   // Decode the handshake against the current state. A start and a done in
   // the same IDLE cycle is a zero-latency transaction; a done with nothing
   // in flight is a protocol error and is not counted.
   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      lastLat_d = lastLat_q;
      startEv   = 1'b0;
      doneEv    = 1'b0;
      errEv     = 1'b0;
      case (state_q)
         IDLE: begin
            if (ap_start) begin
               startEv = 1'b1;
               if (ap_done) begin
                  doneEv    = 1'b1;
                  lat_d     = '0;
                  lastLat_d = '0;
                  state_d   = ap_continue ? IDLE : DONE_HOLD;
               end else begin
                  lat_d   = CNT_W'(1);
                  state_d = BUSY;
               end
            end else if (ap_done) begin
               errEv = 1'b1;
            end
         end
         BUSY: begin
            if (ap_done) begin
               doneEv    = 1'b1;
               lastLat_d = lat_q;
               state_d   = ap_continue ? IDLE : DONE_HOLD;
            end else begin
               lat_d = CNT_W'(satInc(MAX_CNT_W'(lat_q), CNT_W));
            end
         end
         DONE_HOLD: begin
            if (ap_done) begin
               errEv = 1'b1;
            end
            if (ap_continue) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Monitor state, latency tracking and sticky flags. The cycle in which
   // finish is first sampled still updates normally, so a coincident done
   // is counted; from the following edge the live-gated registers hold.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         lat_q      <= '0;
         lastLat_q  <= '0;
         err_q      <= 1'b0;
         finished_q <= 1'b0;
`ifdef NODF_LAT_STATS_EN
         minLat_q   <= '1;
         maxLat_q   <= '0;
`endif
      end else begin
         finished_q <= finished_q | finish;
         err_q      <= err_q | errEv;
         if (live) begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            lastLat_q <= lastLat_d;
`ifdef NODF_LAT_STATS_EN
            if (doneEv) begin
               if (lastLat_d < minLat_q) begin
                  minLat_q <= lastLat_d;
               end
               if (lastLat_d > maxLat_q) begin
                  maxLat_q <= lastLat_d;
               end
            end
`endif
         end
      end
   end

   nodf_sat_counter #(.CNT_W(CNT_W)) uStartCnt (
      .clock (clock),
      .reset (reset),
      .en_i  (startEv & live),
      .cnt_o (start_cnt)
   );

   nodf_sat_counter #(.CNT_W(CNT_W)) uDoneCnt (
      .clock (clock),
      .reset (reset),
      .en_i  (doneEv & live),
      .cnt_o (done_cnt)
   );

   nodf_sat_counter #(.CNT_W(CNT_W)) uReadyCnt (
      .clock (clock),
      .reset (reset),
      .en_i  (ap_ready & live),
      .cnt_o (ready_cnt)
   );

   assign state         = state_q;
   assign last_lat      = lastLat_q;
   assign err_done_idle = err_q;
   assign finished      = finished_q;
`ifdef NODF_LAT_STATS_EN
   assign min_lat       = minLat_q;
   assign max_lat       = maxLat_q;
`endif

endmodule

// File: tb/tb_nodf_module_intf.sv
// -----------------------------------------------------------------------------
// tb_nodf_module_intf
// Directed bench for nodf_module_intf: a default-width instance for the
// handshake scenarios plus a CNT_W=4 instance for counter saturation.
// Build option: NODF_LAT_STATS_EN adds the min/max latency scenario.
// -----------------------------------------------------------------------------
module tb_nodf_module_intf;

   logic        clock = 1'b0;
   logic        reset;
   logic        apStart, apReady, apDone, apContinue, finish;
   logic [1:0]  state;
   logic [31:0] startCnt, doneCnt, readyCnt, lastLat;
   logic        errDoneIdle, finished;
`ifdef NODF_LAT_STATS_EN
   logic [31:0] minLat, maxLat;
`endif

   logic        sReady;
   logic [1:0]  sState;
   logic [3:0]  sStartCnt, sDoneCnt, sReadyCnt, sLastLat;
   logic        sErr, sFinished;
`ifdef NODF_LAT_STATS_EN
   logic [3:0]  sMinLat, sMaxLat;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   nodf_module_intf dut (
      .clock         (clock),
      .reset         (reset),
      .ap_start      (apStart),
      .ap_ready      (apReady),
      .ap_done       (apDone),
      .ap_continue   (apContinue),
      .finish        (finish),
      .state         (state),
      .start_cnt     (startCnt),
      .done_cnt      (doneCnt),
      .ready_cnt     (readyCnt),
      .last_lat      (lastLat),
      .err_done_idle (errDoneIdle),
      .finished      (finished)
`ifdef NODF_LAT_STATS_EN
      ,
      .min_lat       (minLat),
      .max_lat       (maxLat)
`endif
   );

   nodf_module_intf #(.CNT_W(4)) dutSmall (
      .clock         (clock),
      .reset         (reset),
      .ap_start      (1'b0),
      .ap_ready      (sReady),
      .ap_done       (1'b0),
      .ap_continue   (1'b0),
      .finish        (1'b0),
      .state         (sState),
      .start_cnt     (sStartCnt),
      .done_cnt      (sDoneCnt),
      .ready_cnt     (sReadyCnt),
      .last_lat      (sLastLat),
      .err_done_idle (sErr),
      .finished      (sFinished)
`ifdef NODF_LAT_STATS_EN
      ,
      .min_lat       (sMinLat),
      .max_lat       (sMaxLat)
`endif
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of handshake inputs, then let the edge pass and settle.
   task automatic applyStimulus(input logic st, input logic rdy, input logic dn,
                                input logic cont, input logic fin);
      apStart    = st;
      apReady    = rdy;
      apDone     = dn;
      apContinue = cont;
      finish     = fin;
      @(posedge clock);
      #1;
   endtask

   // Start, (lat-1) busy cycles, then done with continue: latency = lat.
   task automatic runTxn(input int lat);
      applyStimulus(1, 0, 0, 0, 0);
      for (int k = 1; k < lat; k++) applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0);
   endtask

   initial begin
      reset = 1'b0;
      sReady = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 0, 1);

      // Reset values (reset also overrides active inputs)
      checkOutput("rst_state", state, 0);
      checkOutput("rst_start_cnt", startCnt, 0);
      checkOutput("rst_done_cnt", doneCnt, 0);
      checkOutput("rst_ready_cnt", readyCnt, 0);
      checkOutput("rst_last_lat", lastLat, 0);
      checkOutput("rst_err", errDoneIdle, 0);
      checkOutput("rst_finished", finished, 0);
`ifdef NODF_LAT_STATS_EN
      checkOutput("rst_min_lat", minLat, 32'hFFFF_FFFF);
      checkOutput("rst_max_lat", maxLat, 0);
`endif
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);

      // Latency-5 transaction
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t1_busy", state, 1);
      checkOutput("t1_start_cnt", startCnt, 1);
      for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t1_still_busy", state, 1);
      applyStimulus(0, 0, 1, 1, 0);
      checkOutput("t1_idle", state, 0);
      checkOutput("t1_last_lat", lastLat, 5);
      checkOutput("t1_done_cnt", doneCnt, 1);

      // Zero-latency transaction with continue
      applyStimulus(1, 0, 1, 1, 0);
      checkOutput("t2_idle", state, 0);
      checkOutput("t2_last_lat", lastLat, 0);
      checkOutput("t2_start_cnt", startCnt, 2);
      checkOutput("t2_done_cnt", doneCnt, 2);

      // Done without continue: three hold cycles, ignored start
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("t3_hold1", state, 2);
      checkOutput("t3_last_lat", lastLat, 1);
      checkOutput("t3_done_cnt", doneCnt, 3);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t3_hold2", state, 2);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t3_hold3", state, 2);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("t3_idle", state, 0);
      checkOutput("t3_start_cnt", startCnt, 3);

      // Zero-latency without continue lands in hold
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("t4_hold", state, 2);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("t4_idle", state, 0);
      checkOutput("t4_done_cnt", doneCnt, 4);

      // Ready pulses with start held low
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 1, 0, 0, 0);
         applyStimulus(0, 0, 0, 0, 0);
      end
      checkOutput("t5_ready_cnt", readyCnt, 4);
      checkOutput("t5_start_cnt", startCnt, 4);
      checkOutput("t5_err", errDoneIdle, 0);

      // Done while idle is an error and not counted
      applyStimulus(0, 0, 1, 1, 0);
      checkOutput("t6_err", errDoneIdle, 1);
      checkOutput("t6_done_cnt", doneCnt, 4);
      checkOutput("t6_state", state, 0);

      // Finish coincident with done, then frozen
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 1);
      checkOutput("t7_finished", finished, 1);
      checkOutput("t7_done_cnt", doneCnt, 5);
      checkOutput("t7_last_lat", lastLat, 1);
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("t7_frozen_start", startCnt, 5);
      checkOutput("t7_frozen_ready", readyCnt, 4);
      checkOutput("t7_frozen_state", state, 0);

      // Reset mid-transaction abandons it
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      reset = 1'b1;
      checkOutput("t8_finished_clr", finished, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("t8_busy", state, 1);
      reset = 1'b0;
      applyStimulus(0, 0, 1, 1, 0);
      reset = 1'b1;
      checkOutput("t8_state", state, 0);
      checkOutput("t8_start_cnt", startCnt, 0);
      checkOutput("t8_done_cnt", doneCnt, 0);

      // CNT_W=4 ready counter saturates at 15
      for (int k = 0; k < 20; k++) begin
         sReady = 1'b1;
         applyStimulus(0, 0, 0, 0, 0);
         if (k == 13) checkOutput("sat_ready_14", sReadyCnt, 14);
      end
      sReady = 1'b0;
      checkOutput("sat_ready_cnt", sReadyCnt, 15);
      checkOutput("sat_start_cnt", sStartCnt, 0);

`ifdef NODF_LAT_STATS_EN
      runTxn(7);
      runTxn(3);
      runTxn(9);
      checkOutput("stats_last_lat", lastLat, 9);
      checkOutput("stats_min_lat", minLat, 3);
      checkOutput("stats_max_lat", maxLat, 9);
`else
      runTxn(3);
      checkOutput("lat3_last_lat", lastLat, 3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
